// File: rtl/sf_result_pipe_if.sv
// Handshake/result bundle for sf_result_pipe: incoming results, control,
// forwarding lookup and register-file writeback.
interface sf_result_pipe_if #(
  parameter int REG_ADDR_WD = 7,
  parameter int REG_DATA_WD = 128
);
  logic                   in_valid;
  logic [REG_ADDR_WD-1:0] in_RT_addr;
  logic [REG_DATA_WD-1:0] in_RT_data;
  logic                   stall;
  logic                   flush;
  logic [REG_ADDR_WD-1:0] fwd_addr;
  logic                   fwd_hit;
  logic [REG_DATA_WD-1:0] fwd_data;
  logic                   wb_en;
  logic [REG_ADDR_WD-1:0] wb_addr;
  logic [REG_DATA_WD-1:0] wb_data;
  logic [2:0]             inflight_cnt;

  modport master (
    output in_valid, in_RT_addr, in_RT_data, stall, flush, fwd_addr,
    input  fwd_hit, fwd_data, wb_en, wb_addr, wb_data, inflight_cnt
  );

  modport slave (
    input  in_valid, in_RT_addr, in_RT_data, stall, flush, fwd_addr,
    output fwd_hit, fwd_data, wb_en, wb_addr, wb_data, inflight_cnt
  );
endinterface

// File: rtl/sf_result_pipe.sv
// Delays simple-fixed results by UNIT_LATENCY stages before register writeback.
// Define SF_RESULT_PIPE_FWD_EN to build the in-flight operand forwarding lookup.
module sf_result_pipe #(
  parameter int REG_ADDR_WD  = 7,
  parameter int REG_DATA_WD  = 128,
  parameter int UNIT_LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  sf_result_pipe_if.slave pipe
);
  logic [UNIT_LATENCY-1:0] stageValid_q, stageValid_d;
  logic [REG_ADDR_WD-1:0]  stageAddr_q [UNIT_LATENCY];
  logic [REG_ADDR_WD-1:0]  stageAddr_d [UNIT_LATENCY];
  logic [REG_DATA_WD-1:0]  stageData_q [UNIT_LATENCY];
  logic [REG_DATA_WD-1:0]  stageData_d [UNIT_LATENCY];
  logic [2:0]              inflightCnt;

  // Flush only kills valid bits; stale addr/data are harmless once invalid.
  always_comb begin
    stageValid_d = stageValid_q;
    stageAddr_d  = stageAddr_q;
    stageData_d  = stageData_q;
    if (pipe.flush) begin
      stageValid_d = '0;
    end else if (!pipe.stall) begin
      stageValid_d[0] = pipe.in_valid;
      stageAddr_d[0]  = pipe.in_RT_addr;
      stageData_d[0]  = pipe.in_RT_data;
      for (int i = 1; i < UNIT_LATENCY; i++) begin
        stageValid_d[i] = stageValid_q[i-1];
        stageAddr_d[i]  = stageAddr_q[i-1];
        stageData_d[i]  = stageData_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q <= '0;
      for (int i = 0; i < UNIT_LATENCY; i++) begin
        stageAddr_q[i] <= '0;
        stageData_q[i] <= '0;
      end
    end else begin
      stageValid_q <= stageValid_d;
      for (int i = 0; i < UNIT_LATENCY; i++) begin
        stageAddr_q[i] <= stageAddr_d[i];
        stageData_q[i] <= stageData_d[i];
      end
    end
  end

  always_comb begin
    inflightCnt = '0;
    for (int i = 0; i < UNIT_LATENCY; i++) begin
      inflightCnt = inflightCnt + 3'(stageValid_q[i]);
    end
  end

  assign pipe.inflight_cnt = inflightCnt;
  assign pipe.wb_en        = stageValid_q[UNIT_LATENCY-1] & ~pipe.stall & ~pipe.flush;
  assign pipe.wb_addr      = stageAddr_q[UNIT_LATENCY-1];
  assign pipe.wb_data      = stageData_q[UNIT_LATENCY-1];

`ifdef SF_RESULT_PIPE_FWD_EN
  logic                   fwdHit;
  logic [REG_DATA_WD-1:0] fwdData;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int i = UNIT_LATENCY - 1; i >= 0; i--) begin
      if (stageValid_q[i] && (stageAddr_q[i] == pipe.fwd_addr)) begin
        fwdHit  = 1'b1;
        fwdData = stageData_q[i];
      end
    end
  end

  assign pipe.fwd_hit  = fwdHit;
  assign pipe.fwd_data = fwdData;
`else
  assign pipe.fwd_hit  = 1'b0;
  assign pipe.fwd_data = '0;
`endif
endmodule

// File: tb/tb_sf_result_pipe.sv
// Self-checking bench for sf_result_pipe: directed vector table, forwarding and
// async-reset sequences, then random traffic against an age-tracking queue model.
module tb_sf_result_pipe;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int UL = 2;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          s;
    logic          f;
    logic          expWe;
    logic [AW-1:0] expA;
    logic [DW-1:0] expD;
    logic [2:0]    expCnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            shifts;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  ent_t modelQ[$];
  logic fwdBuilt;

  sf_result_pipe_if #(.REG_ADDR_WD(AW), .REG_DATA_WD(DW)) bus ();

  sf_result_pipe #(.REG_ADDR_WD(AW), .REG_DATA_WD(DW), .UNIT_LATENCY(UL)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic s, input logic f, input logic [AW-1:0] fa);
    bus.in_valid   = v;
    bus.in_RT_addr = a;
    bus.in_RT_data = d;
    bus.stall      = s;
    bus.flush      = f;
    bus.fwd_addr   = fa;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wb_en"}, DW'(bus.wb_en), '0);
    checkOutput({tag, "_wb_addr"}, DW'(bus.wb_addr), '0);
    checkOutput({tag, "_wb_data"}, bus.wb_data, '0);
    checkOutput({tag, "_cnt"}, DW'(bus.inflight_cnt), '0);
    checkOutput({tag, "_fwd_hit"}, DW'(bus.fwd_hit), '0);
    checkOutput({tag, "_fwd_data"}, bus.fwd_data, '0);
  endtask

  task automatic addRow(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic s, input logic f, input logic we,
                        input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic [2:0] cnt);
    vecs.push_back('{v, a, d, s, f, we, ea, ed, cnt});
  endtask

  // Expected outputs from the queue of in-flight results and their shift ages.
  task automatic modelCheck(input logic s, input logic f, input logic [AW-1:0] fa);
    logic          expHit = 1'b0;
    logic [DW-1:0] expFwd = '0;
    checkOutput("rnd_cnt", DW'(bus.inflight_cnt), DW'(modelQ.size()));
    if (modelQ.size() > 0 && modelQ[0].shifts == UL - 1) begin
      checkOutput("rnd_wb_en", DW'(bus.wb_en), DW'(!s && !f));
      checkOutput("rnd_wb_addr", DW'(bus.wb_addr), DW'(modelQ[0].addr));
      checkOutput("rnd_wb_data", bus.wb_data, modelQ[0].data);
    end else begin
      checkOutput("rnd_wb_en", DW'(bus.wb_en), '0);
    end
    if (fwdBuilt) begin
      for (int i = modelQ.size() - 1; i >= 0; i--) begin
        if (modelQ[i].addr == fa) begin
          expHit = 1'b1;
          expFwd = modelQ[i].data;
          break;
        end
      end
    end
    checkOutput("rnd_fwd_hit", DW'(bus.fwd_hit), DW'(expHit));
    checkOutput("rnd_fwd_data", bus.fwd_data, expFwd);
  endtask

  task automatic modelUpdate(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic s, input logic f);
    if (f) begin
      modelQ.delete();
    end else if (!s) begin
      foreach (modelQ[i]) modelQ[i].shifts++;
      if (modelQ.size() > 0 && modelQ[0].shifts == UL) void'(modelQ.pop_front());
      if (v) modelQ.push_back('{a, d, 0});
    end
  endtask

  initial begin
`ifdef SF_RESULT_PIPE_FWD_EN
    fwdBuilt = 1'b1;
`else
    fwdBuilt = 1'b0;
`endif
    applyStimulus(0, '0, '0, 0, 0, '0);

    // Latency, back-to-back, stall, flush and flush-over-input vectors.
    addRow(1, 5, 'h17, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 0, 0, 1, 5, 'h17, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 1, 'h101, 0, 0, 0, 0, 0, 0);
    addRow(1, 2, 'h202, 0, 0, 0, 0, 0, 1);
    addRow(1, 3, 'h303, 0, 0, 1, 1, 'h101, 2);
    addRow(0, 0, 0, 0, 0, 1, 2, 'h202, 2);
    addRow(0, 0, 0, 0, 0, 1, 3, 'h303, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 7, 'h77, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 0, 1, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 1, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 1, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 0, 0, 1, 7, 'h77, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 4, 'h44, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 1);
    addRow(1, 6, 'h66, 1, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 0, 0, 1, 4, 'h44, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 1, 'h11, 0, 0, 0, 0, 0, 0);
    addRow(1, 2, 'h22, 0, 0, 0, 0, 0, 1);
    addRow(0, 0, 0, 1, 1, 0, 0, 0, 2);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addRow(1, 3, 'h33, 0, 1, 0, 0, 0, 0);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #2;
    checkAllZero("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].f, '0);
      #1;
      checkOutput($sformatf("vec%0d_wb_en", i), DW'(bus.wb_en), DW'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d_cnt", i), DW'(bus.inflight_cnt), DW'(vecs[i].expCnt));
      if (vecs[i].expWe) begin
        checkOutput($sformatf("vec%0d_wb_addr", i), DW'(bus.wb_addr), DW'(vecs[i].expA));
        checkOutput($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].expD);
      end
      nextCycle();
    end

    // Two writes to the same register in flight: youngest forwards, both write back.
    applyStimulus(1, 9, 'hAAAA, 0, 0, 9);
    nextCycle();
    applyStimulus(1, 9, 'hBBBB, 0, 0, 9);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 9);
    #1;
    checkOutput("fwd_cnt", DW'(bus.inflight_cnt), 2);
    checkOutput("fwd_hit9", DW'(bus.fwd_hit), DW'(fwdBuilt));
    checkOutput("fwd_data9", bus.fwd_data, fwdBuilt ? DW'('hBBBB) : '0);
    checkOutput("fwd_wb_a", bus.wb_data, 'hAAAA);
    bus.fwd_addr = 10;
    #1;
    checkOutput("fwd_hit10", DW'(bus.fwd_hit), 0);
    checkOutput("fwd_data10", bus.fwd_data, 0);
    nextCycle();
    bus.fwd_addr = 9;
    #1;
    checkOutput("fwd_wb_b_en", DW'(bus.wb_en), 1);
    checkOutput("fwd_wb_b", bus.wb_data, 'hBBBB);
    checkOutput("fwd_hit9_late", DW'(bus.fwd_hit), DW'(fwdBuilt));
    nextCycle();

    // Reset mid-flight discards both results.
    applyStimulus(1, 2, 'h2222, 0, 0, 3);
    nextCycle();
    applyStimulus(1, 3, 'h3333, 0, 0, 3);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 3);
    #1;
    checkOutput("rst_pre_cnt", DW'(bus.inflight_cnt), 2);
    #1 rst = 1'b1;
    #1;
    checkAllZero("rst_async");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("rst_after%0d_wb_en", c), DW'(bus.wb_en), 0);
      checkOutput($sformatf("rst_after%0d_cnt", c), DW'(bus.inflight_cnt), 0);
      nextCycle();
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic          v, s, f;
      logic [AW-1:0] a, fa;
      logic [DW-1:0] d;
      v  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 19) == 0);
      a  = AW'($urandom_range(0, 15));
      fa = AW'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(v, a, d, s, f, fa);
      #1;
      modelCheck(s, f, fa);
      @(posedge clk);
      modelUpdate(v, a, d, s, f);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sf_result_pipe.md
SF_RESULT_PIPE -- requirements
Module: sf_result_pipe

Interface
REQ-001 Parameter: REG_ADDR_WD, default 7, register-file address width.
REQ-002 Parameter: REG_DATA_WD, default 128, result width.
REQ-003 Parameter: UNIT_LATENCY, default 2, stages from accept to writeback, legal range 1..7.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  simple-fixed result present this cycle.
REQ-007 in_RT_addr  input  REG_ADDR_WD  target register of the result.
REQ-008 in_RT_data  input  REG_DATA_WD  result word (out_RT of the simple-fixed unit).
REQ-009 stall  input  1  freeze all stages.
REQ-010 flush  input  1  kill all in-flight results.
REQ-011 fwd_addr  input  REG_ADDR_WD  operand address for forwarding lookup.
REQ-012 fwd_hit  output  1  fwd_addr matches an in-flight valid result.
REQ-013 fwd_data  output  REG_DATA_WD  youngest matching in-flight result.
REQ-014 wb_en  output  1  register-file write strobe.
REQ-015 wb_addr  output  REG_ADDR_WD  write address.
REQ-016 wb_data  output  REG_DATA_WD  write data.
REQ-017 inflight_cnt  output  3  number of valid stages, 0..UNIT_LATENCY.

Function
REQ-018 Pipeline SHALL hold UNIT_LATENCY stages, each {valid, addr, data}; stage 0 youngest, stage UNIT_LATENCY-1 oldest.
REQ-019 Accept: in_valid & !stall & !flush at edge N loads stage 0; result presented on wb_* during cycle N+UNIT_LATENCY-1+1, i.e. UNIT_LATENCY cycles after acceptance with no stalls.
REQ-020 When !stall, every stage SHALL shift one position per cycle; stage 0 loads in_valid (0 if not accepted).
REQ-021 When stall=1, all stages SHALL hold; in_valid SHALL be ignored (upstream holds it).
REQ-022 wb_en SHALL equal oldest-stage valid & !stall & !flush; wb_addr/wb_data SHALL be the oldest stage fields, driven whatever wb_en.
REQ-023 flush=1 SHALL clear every stage valid at the next edge, override stall and in_valid, and force wb_en=0 combinationally in the flush cycle.
REQ-024 Simultaneous stall and flush: flush wins.
REQ-025 inflight_cnt SHALL be the population count of stage valid bits, updated combinationally from registered state.
REQ-026 Forwarding (when compiled in): fwd_hit=1 if any valid stage has addr==fwd_addr; fwd_data from the youngest such stage; incoming in_* not searched.
REQ-027 Duplicate target addresses in flight SHALL all write back in order; no coalescing.
REQ-028 Data SHALL pass bit-exact, no width conversion.

Reset
REQ-029 rst=1 SHALL asynchronously clear all stage valid bits, addr and data to 0.
REQ-030 During and after reset: wb_en=0, wb_addr=0, wb_data=0, fwd_hit=0, fwd_data=0, inflight_cnt=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight results; no writeback occurs for them.

Configuration
REQ-032 Macro SF_RESULT_PIPE_FWD_EN defined: forwarding comparators and fwd_data mux per REQ-026 present.
REQ-033 Macro undefined: fwd_hit tied 0, fwd_data tied 0, fwd_addr unused; all other behaviour unchanged.

Verification
REQ-034 Latency: UNIT_LATENCY=2, in_valid=1 addr=5 data=0x0017 repeated x8 at cycle 1 -> wb_en=1 addr=5 same data at cycle 3, one cycle only.
REQ-035 Back-to-back: addrs 1,2,3 on consecutive cycles -> wb_en on three consecutive cycles in order 1,2,3; inflight_cnt peaks at 2.
REQ-036 Stall: accept addr=7, stall 3 cycles after acceptance -> wb_en=0 during stall, single write of addr=7 the cycle after stall drops.
REQ-037 Flush: two results in flight, flush=1 with stall=1 -> wb_en=0 that cycle, inflight_cnt=0 next cycle, no later write.
REQ-038 Forwarding (FWD_EN): addr=9 data A then addr=9 data B in flight, fwd_addr=9 -> fwd_hit=1 fwd_data=B; fwd_addr=10 -> fwd_hit=0; without macro fwd_hit=0 always.
REQ-039 Async reset: rst pulsed mid-cycle with 2 results in flight -> all outputs 0 immediately, no writeback after release.
